// File: rtl/candy_if_pkg.sv
// Shared definitions for the candy CPU instruction-fetch stage:
// SRAM widths, reset polarity and the fetch FSM state encoding.
package candy_if_pkg;

  localparam int SRAM_ADDR_W = 17;
  localparam int SRAM_DATA_W = 24;
  localparam logic RST_ENABLE  = 1'b1;
  localparam logic RST_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_DONE = 2'd2
  } if_state_t;

endpackage

// File: rtl/candy_if_if.sv
// Fetch-stage bundle: pipeline request, SRAM handshake, and fetched word.
// The master side is the fetch stage; the slave side is pipeline control and SRAM.
interface candy_if_if #(
  parameter int ADDR_W = candy_if_pkg::SRAM_ADDR_W,
  parameter int DATA_W = candy_if_pkg::SRAM_DATA_W
);

  logic [ADDR_W-1:0] pc;
  logic              if_enable;
  logic              data_ready;
  logic [DATA_W-1:0] sram_data;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_read_enable;
  logic              is_mem;

  modport master (
    input  pc, if_enable, data_ready, sram_data,
    output inst, sram_addr, sram_read_enable, is_mem
  );

  modport slave (
    output pc, if_enable, data_ready, sram_data,
    input  inst, sram_addr, sram_read_enable, is_mem
  );

endinterface

// File: rtl/candy_if.sv
// Instruction fetch: launches one SRAM read at pc, waits for data_ready,
// and holds the captured word on inst. All outputs are registered.
module candy_if
  import candy_if_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  candy_if_if.master   bus
);

  if_state_t         state_reg;
  logic [DATA_W-1:0] inst_reg;
  logic [ADDR_W-1:0] sram_addr_reg;
  logic              sram_read_enable_reg;
  logic              is_mem_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state_reg            <= IF_IDLE;
      inst_reg             <= '0;
      sram_addr_reg        <= '0;
      sram_read_enable_reg <= 1'b0;
      is_mem_reg           <= 1'b0;
    end else begin
      case (state_reg)
        IF_IDLE: begin
          // data_ready is deliberately not looked at here: launch only
          if (bus.if_enable) begin
            sram_addr_reg        <= bus.pc;
            sram_read_enable_reg <= 1'b1;
            is_mem_reg           <= 1'b1;
            state_reg            <= IF_WAIT;
          end
        end
        IF_WAIT: begin
          // Request stays frozen until the SRAM answers, whatever pc does
          if (bus.data_ready) begin
            inst_reg             <= bus.sram_data;
            sram_read_enable_reg <= 1'b0;
            is_mem_reg           <= 1'b0;
            state_reg            <= IF_DONE;
          end
        end
        IF_DONE: begin
          if (!bus.if_enable) begin
            state_reg <= IF_IDLE;
          end else if (bus.pc != sram_addr_reg) begin
            sram_addr_reg        <= bus.pc;
            sram_read_enable_reg <= 1'b1;
            is_mem_reg           <= 1'b1;
            state_reg            <= IF_WAIT;
          end
        end
        default: state_reg <= IF_IDLE;
      endcase
    end
  end

  assign bus.inst             = inst_reg;
  assign bus.sram_addr        = sram_addr_reg;
  assign bus.sram_read_enable = sram_read_enable_reg;
  assign bus.is_mem           = is_mem_reg;

endmodule

// File: tb/tb_candy_if.sv
// Directed bench for candy_if: a vector table of per-edge stimulus and
// expected registered outputs, plus a hand sequence for reset mid-fetch.
module tb_candy_if;
  import candy_if_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  candy_if_if #(.ADDR_W(SRAM_ADDR_W), .DATA_W(SRAM_DATA_W)) bus ();

  candy_if #(.ADDR_W(SRAM_ADDR_W), .DATA_W(SRAM_DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        if_enable;
    logic [16:0] pc;
    logic        data_ready;
    logic [23:0] sram_data;
    logic [23:0] exp_inst;
    logic [16:0] exp_addr;
    logic        exp_re;
    logic        exp_mem;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [23:0] e_inst,
                           input logic [16:0] e_addr, input logic e_re, input logic e_mem);
    check({tag, ".inst"},             {8'h0, bus.inst},             {8'h0, e_inst});
    check({tag, ".sram_addr"},        {15'h0, bus.sram_addr},       {15'h0, e_addr});
    check({tag, ".sram_read_enable"}, {31'h0, bus.sram_read_enable}, {31'h0, e_re});
    check({tag, ".is_mem"},           {31'h0, bus.is_mem},          {31'h0, e_mem});
    $display("txn %s inst=%h addr=%h re=%b mem=%b", tag, bus.inst, bus.sram_addr,
             bus.sram_read_enable, bus.is_mem);
  endtask

  task automatic drive(input logic r, input logic en, input logic [16:0] p,
                       input logic dr, input logic [23:0] d);
    rst            = r;
    bus.if_enable  = en;
    bus.pc         = p;
    bus.data_ready = dr;
    bus.sram_data  = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //         rst  en    pc       dr    data        inst        addr     re    mem
    vecs[0]  = '{1'b1, 1'b0, 17'h000, 1'b0, 24'h000000, 24'h000000, 17'h000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 17'h012, 1'b0, 24'h000000, 24'h000000, 17'h012, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 17'h012, 1'b1, 24'h027890, 24'h027890, 17'h012, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 17'h012, 1'b1, 24'h0BAD00, 24'h027890, 17'h012, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 17'h012, 1'b1, 24'h0BAD01, 24'h027890, 17'h012, 1'b0, 1'b0};
    // IDLE with request and data_ready on the same edge: launch only
    vecs[5]  = '{1'b0, 1'b1, 17'h012, 1'b1, 24'h111111, 24'h027890, 17'h012, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 17'h0FF, 1'b0, 24'h222222, 24'h027890, 17'h012, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 17'h0FF, 1'b0, 24'h222222, 24'h027890, 17'h012, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 17'h0FF, 1'b0, 24'h222222, 24'h027890, 17'h012, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 17'h0FF, 1'b0, 24'h222222, 24'h027890, 17'h012, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 17'h0FF, 1'b0, 24'h222222, 24'h027890, 17'h012, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 17'h012, 1'b1, 24'h135790, 24'h135790, 17'h012, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 17'h013, 1'b0, 24'h000000, 24'h135790, 17'h013, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 17'h013, 1'b1, 24'hABCDEF, 24'hABCDEF, 17'h013, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 17'h013, 1'b0, 24'h000000, 24'hABCDEF, 17'h013, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 17'h013, 1'b0, 24'h000000, 24'hABCDEF, 17'h013, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 17'h013, 1'b1, 24'h000055, 24'hABCDEF, 17'h013, 1'b0, 1'b0};

    // Reset held from time 0: outputs must already be clear before any edge
    drive(1'b1, 1'b0, 17'h000, 1'b0, 24'h000000);
    #1;
    check_all("reset_async", 24'h0, 17'h0, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].if_enable, vecs[i].pc, vecs[i].data_ready, vecs[i].sram_data);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_inst, vecs[i].exp_addr,
                vecs[i].exp_re, vecs[i].exp_mem);
    end

    // Launch a fetch, then hit reset between edges while it is outstanding
    drive(1'b0, 1'b1, 17'h1AB, 1'b0, 24'h000000);
    @(posedge clk);
    #1;
    check_all("midwait_launch", 24'hABCDEF, 17'h1AB, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_all("midwait_rst", 24'h0, 17'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    // Back in IDLE: a high data_ready with no request must not capture
    drive(1'b0, 1'b0, 17'h1AB, 1'b1, 24'hFFFFFF);
    @(posedge clk);
    #1;
    check_all("post_rst_idle", 24'h0, 17'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 17'h005, 1'b0, 24'hFFFFFF);
    @(posedge clk);
    #1;
    check_all("post_rst_launch", 24'h0, 17'h005, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 17'h005, 1'b1, 24'h5A5A5A);
    @(posedge clk);
    #1;
    check_all("post_rst_capture", 24'h5A5A5A, 17'h005, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
